// File: rtl/stepper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : stepper_pkg                                             |
// | Description: Shared types and constants for the stepper sequencer:   |
// |              FSM state encoding, 8-entry coil phase table and the    |
// |              phase-index increments for half and full stepping.      |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package stepper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Phase-index increments: half-step moves one table slot, full-step two.
   localparam logic [2:0] c_idx_step_half = 3'd1;
   localparam logic [2:0] c_idx_step_full = 3'd2;

   // Coil patterns {A,B,C,D}; element [0] is the rightmost entry.
   localparam logic [7:0][3:0] c_phase_table = {
      4'b1001,   // idx 7
      4'b0001,   // idx 6
      4'b0011,   // idx 5
      4'b0010,   // idx 4
      4'b0110,   // idx 3
      4'b0100,   // idx 2
      4'b1100,   // idx 1
      4'b1000    // idx 0
   };

endpackage
`default_nettype wire

// File: rtl/step_phase_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : step_phase_lut                                          |
// | Description: Combinational map from 3-bit phase index to the 4-bit   |
// |              coil pattern {A,B,C,D}.                                 |
// | Ports      : idx     in  [2:0]  phase index                          |
// |              pattern out [3:0]  coil pattern for idx                 |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module step_phase_lut
   import stepper_pkg::*;
(
   input  logic [2:0] idx,
   output logic [3:0] pattern
);

   assign pattern = c_phase_table[idx];

endmodule
`default_nettype wire

// File: rtl/stepper_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : stepper_sequencer                                       |
// | Description: Executes move commands on a 4-coil stepper motor.       |
// |              Each step_pulse in RUN advances the phase index, the    |
// |              signed position and the remaining-step count; the coil  |
// |              drive is registered one cycle behind the index.         |
// | Ports      : F50M        in   system clock (rising edge)             |
// |              RESET       in   asynchronous active-low reset          |
// |              step_pulse  in   one-cycle step tick                    |
// |              cmd_valid   in   command offered                        |
// |              cmd_ready   out  high in IDLE                           |
// |              cmd_steps   in   [STEPS_W-1:0] steps to move            |
// |              cmd_dir     in   1 = forward, 0 = reverse               |
// |              cmd_half    in   1 = half-step, 0 = full-step           |
// |              abort       in   terminate current move                 |
// |              hold        in   keep coils energised when not moving   |
// |              coil        out  [3:0] registered coil drive {A,B,C,D}  |
// |              busy        out  high in RUN                            |
// |              done        out  one-cycle completion/abort pulse       |
// |              position    out  [POS_W-1:0] signed step count          |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module stepper_sequencer
   import stepper_pkg::*;
#(
   parameter int STEPS_W = 16,
   parameter int POS_W   = 16
)
(
   input  logic               F50M,
   input  logic               RESET,
   input  logic               step_pulse,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [STEPS_W-1:0] cmd_steps,
   input  logic               cmd_dir,
   input  logic               cmd_half,
   input  logic               abort,
   input  logic               hold,
   output logic [3:0]         coil,
   output logic               busy,
   output logic               done,
   output logic [POS_W-1:0]   position
);

   localparam logic [POS_W-1:0]   c_pos_one   = POS_W'(1);
   localparam logic [STEPS_W-1:0] c_steps_one = STEPS_W'(1);

   state_t               r_state;
   state_t               w_next_state;
   logic [2:0]           r_idx;
   logic [STEPS_W-1:0]   r_remaining;
   logic [POS_W-1:0]     r_position;
   logic                 r_dir;
   logic                 r_half;
   logic [3:0]           r_coil;

   logic                 w_accept;
   logic                 w_take_step;
   logic [2:0]           w_idx_delta;
   logic [2:0]           w_idx_next;
   logic [POS_W-1:0]     w_pos_next;
   logic [3:0]           w_pattern;

   assign w_accept    = cmd_valid && (r_state == ST_IDLE);
   // Abort takes priority over a coincident step tick.
   assign w_take_step = (r_state == ST_RUN) && step_pulse && !abort;

   // 3-bit index arithmetic wraps modulo 8 by construction.
   assign w_idx_delta = r_half ? c_idx_step_half : c_idx_step_full;
   assign w_idx_next  = r_dir ? (r_idx + w_idx_delta) : (r_idx - w_idx_delta);
   assign w_pos_next  = r_dir ? (r_position + c_pos_one) : (r_position - c_pos_one);

   step_phase_lut u_lut (
      .idx     (r_idx),
      .pattern (w_pattern)
   );

   // State register
   always_ff @(posedge F50M or negedge RESET) begin
      if (!RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = (cmd_steps == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               w_next_state = ST_DONE;
            end else if (w_take_step && (r_remaining == c_steps_one)) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Move datapath and registered coil drive. The coil follows the index
   // register, so a step taken at one edge shows on the coils at the next.
   always_ff @(posedge F50M or negedge RESET) begin
      if (!RESET) begin
         r_idx       <= 3'd0;
         r_remaining <= '0;
         r_position  <= '0;
         r_dir       <= 1'b0;
         r_half      <= 1'b0;
         r_coil      <= 4'b0000;
      end else begin
         if (w_accept) begin
            r_dir       <= cmd_dir;
            r_half      <= cmd_half;
            r_remaining <= cmd_steps;
         end else if ((r_state == ST_RUN) && abort) begin
            r_remaining <= '0;
         end else if (w_take_step) begin
            r_idx       <= w_idx_next;
            r_remaining <= r_remaining - c_steps_one;
            r_position  <= w_pos_next;
         end
         r_coil <= ((r_state == ST_RUN) || hold) ? w_pattern : 4'b0000;
      end
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_RUN);
   assign done      = (r_state == ST_DONE);
   assign coil      = r_coil;
   assign position  = r_position;

endmodule
`default_nettype wire

// File: doc/stepper_sequencer.md
STEPPER_SEQUENCER -- requirements
Module: stepper_sequencer

Interface
REQ-001 Parameter STEPS_W, default 16: width of move length and remaining-step counter.
REQ-002 Parameter POS_W, default 16: width of signed position counter.
REQ-003 F50M  input  1  system clock, 50 MHz; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 step_pulse  input  1  one-cycle step tick from the upstream frequency divider.
REQ-006 cmd_valid  input  1  move command offered.
REQ-007 cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_steps  input  STEPS_W  number of steps to move, unsigned.
REQ-009 cmd_dir  input  1  1 = forward (phase index +), 0 = reverse.
REQ-010 cmd_half  input  1  1 = half-step (index ±1), 0 = full-step (index ±2).
REQ-011 abort  input  1  terminate current move.
REQ-012 hold  input  1  1 = keep coils energised when not moving.
REQ-013 coil  output  4  registered coil drive {A,B,C,D}.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse on move completion or abort.
REQ-016 position  output  POS_W  signed accumulated step count.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE -> RUN on accept with cmd_steps != 0; cmd_dir, cmd_half and cmd_steps are latched at accept.
REQ-019 IDLE -> DONE on accept with cmd_steps == 0; no coil or position change.
REQ-020 RUN: each step_pulse advances the 3-bit phase index by ±1 (half) or ±2 (full), modulo 8, decrements remaining by 1, and adds ±1 to position.
REQ-021 Coil update latency: step_pulse sampled at edge n produces the new coil value after edge n+1.
REQ-022 Phase table: idx0 1000, 1 1100, 2 0100, 3 0110, 4 0010, 5 0011, 6 0001, 7 1001.
REQ-023 RUN -> DONE in the cycle the step that brings remaining to 0 is applied.
REQ-024 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-025 abort in RUN -> DONE next edge; remaining steps are discarded; phase index and position keep their last values.
REQ-026 abort and step_pulse in the same RUN cycle: abort wins and no step is taken.
REQ-027 step_pulse in IDLE or DONE is ignored; abort in IDLE or DONE is ignored.
REQ-028 cmd_valid outside IDLE is not accepted; cmd_ready=0 there.
REQ-029 Phase index persists across moves; it is not reset by a new command.
REQ-030 position wraps two's-complement modulo 2^POS_W with no saturation.
REQ-031 coil = table[idx] in RUN, or in IDLE/DONE when hold=1; otherwise coil = 0000.

Reset
REQ-032 RESET low asynchronously forces: state IDLE, idx 0, remaining 0, position 0, coil 0000, busy 0, done 0.
REQ-033 Reset mid-move abandons the move without a done pulse; cmd_ready is high on the first edge after RESET deasserts.

Structure
REQ-034 Package stepper_pkg holds the FSM state encoding, the 8-entry phase table constant, and the index-step constants (1, 2).
REQ-035 One combinational sub-module, step_phase_lut, maps the 3-bit index to the 4-bit coil pattern; coil is registered in stepper_sequencer.

Verification
REQ-036 Forward half-step, cmd_steps=3 from idx0, 3 pulses -> coil 1100, 0100, 0110; position=3; one done pulse; busy low after done.
REQ-037 Reverse full-step, cmd_steps=2 from idx0 -> coil 0001 then 0010; position=-2; idx=4.
REQ-038 cmd_steps=0 -> done pulse one cycle after accept; coil and position unchanged; no busy.
REQ-039 Abort coinciding with the 2nd pulse of a 5-step move -> exactly 1 step taken, done pulses once, cmd_ready returns.
REQ-040 position=0x7FFF plus 1 forward step -> 0x8000; hold=0 in IDLE -> coil 0000; hold=1 -> coil = last table value.
REQ-041 RESET asserted mid-RUN -> all outputs reach reset values immediately, with no done pulse.
